// File: rtl/clock_pkg.sv
// Shared types and constants for the Millennium Clock front-panel setting logic.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_SEC,
    SET_MIN,
    SET_HOUR,
    SET_DAY,
    SET_MON,
    SET_YEAR
  } set_state_t;

  localparam int NUM_SET_FIELDS = 6;
  localparam int FLD_SEC        = 0;
  localparam int FLD_MIN        = 1;
  localparam int FLD_HOUR       = 2;
  localparam int FLD_DAY        = 3;
  localparam int FLD_MON        = 4;
  localparam int FLD_YEAR       = 5;
  localparam int BLINK_CNT_W    = 24;

  function automatic set_state_t next_state(set_state_t s);
    case (s)
      RUN:      next_state = SET_SEC;
      SET_SEC:  next_state = SET_MIN;
      SET_MIN:  next_state = SET_HOUR;
      SET_HOUR: next_state = SET_DAY;
      SET_DAY:  next_state = SET_MON;
      SET_MON:  next_state = SET_YEAR;
      default:  next_state = RUN;
    endcase
  endfunction

  function automatic logic [NUM_SET_FIELDS-1:0] field_sel(set_state_t s);
    field_sel = '0;
    case (s)
      SET_SEC:  field_sel[FLD_SEC]  = 1'b1;
      SET_MIN:  field_sel[FLD_MIN]  = 1'b1;
      SET_HOUR: field_sel[FLD_HOUR] = 1'b1;
      SET_DAY:  field_sel[FLD_DAY]  = 1'b1;
      SET_MON:  field_sel[FLD_MON]  = 1'b1;
      SET_YEAR: field_sel[FLD_YEAR] = 1'b1;
      default:  field_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-count debouncer and rising-edge flag.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // stage boundary: synchronized level -> debounced level
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time/date setting controller. Optional auto-repeat of UP/DOWN
// is enabled by defining TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1500000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      btn_mode,
  input  logic                      btn_up,
  input  logic                      btn_down,
  output logic                      set_enable,
  output logic [NUM_SET_FIELDS-1:0] set_mode,
  output logic                      inc,
  output logic                      dec,
  output logic                      blink
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic mode_lvl, mode_rise;
  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;
  logic rpt_up, rpt_dn;
  logic mode_pend, mode_go;

  set_state_t             state;
  set_state_t             adv_state;
  logic [TW-1:0]          tmo_cnt;
  logic [BLINK_CNT_W-1:0] blink_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rstn(rstn), .btn(btn_mode), .level(mode_lvl), .rise(mode_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rstn(rstn), .btn(btn_up), .level(up_lvl), .rise(up_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rstn(rstn), .btn(btn_down), .level(dn_lvl), .rise(dn_rise)
  );

  // A MODE edge landing right after a pulse is held one cycle so set_mode
  // stays put in the cycle following every inc/dec.
  assign mode_go   = mode_rise | mode_pend;
  assign adv_state = next_state(state);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed;
  logic          rpt_hold;
  logic          rpt_hit;
  logic          unused_mode_lvl;

  assign rpt_hold = (state != RUN) && (up_lvl ^ dn_lvl);
  assign rpt_hit  = rpt_hold && !(up_rise || dn_rise || mode_go) &&
                    (rpt_cnt == (rpt_armed ? RPT_NEXT : RPT_FIRST));
  assign rpt_up   = rpt_hit & up_lvl;
  assign rpt_dn   = rpt_hit & dn_lvl;
  assign unused_mode_lvl = mode_lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!rpt_hold || up_rise || dn_rise || mode_go) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_hit) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else if (rpt_cnt != '1) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_lvl;

  assign rpt_up     = 1'b0;
  assign rpt_dn     = 1'b0;
  assign unused_lvl = &{1'b0, mode_lvl, up_lvl, dn_lvl};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      set_enable <= 1'b0;
      set_mode   <= '0;
      inc        <= 1'b0;
      dec        <= 1'b0;
      blink      <= 1'b0;
      blink_cnt  <= '0;
      tmo_cnt    <= '0;
      mode_pend  <= 1'b0;
    end else begin
      inc       <= 1'b0;
      dec       <= 1'b0;
      mode_pend <= 1'b0;
      if (state != RUN) begin
        blink_cnt <= blink_cnt + 1'b1;
        if (&blink_cnt) blink <= ~blink;
      end
      if (mode_go) begin
        if (inc || dec) begin
          mode_pend <= 1'b1;
        end else begin
          state      <= adv_state;
          set_enable <= (adv_state != RUN);
          set_mode   <= field_sel(adv_state);
          tmo_cnt    <= '0;
          if (adv_state == RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
          end
        end
      end else if (state != RUN) begin
        if (up_rise || dn_rise || rpt_up || rpt_dn) begin
          tmo_cnt <= '0;
          inc     <= (up_rise & ~dn_rise) | rpt_up;
          dec     <= (dn_rise & ~up_rise) | rpt_dn;
        end else if (tmo_cnt == TMO_LAST) begin
          state      <= RUN;
          set_enable <= 1'b0;
          set_mode   <= '0;
          blink      <= 1'b0;
          blink_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/timeout/repeat parameters.
module tb_time_set_ctrl;

  localparam int DB = 4;
  localparam int TO = 100;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       set_enable;
  logic [5:0] set_mode;
  logic       inc;
  logic       dec;
  logic       blink;

  int n_cmp = 0;
  int n_mis = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;
  int both_cnt = 0;
  int snap_inc;
  int snap_dec;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .set_enable(set_enable),
    .set_mode  (set_mode),
    .inc       (inc),
    .dec       (dec),
    .blink     (blink)
  );

  always @(negedge clk) begin
    if (inc) inc_cnt++;
    if (dec) dec_cnt++;
    if (inc && dec) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(10);
    btn_mode = 1'b0;
    step(8);
  endtask

  initial begin
    rstn = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(3);
    chk("rst_en", set_enable, 0);
    chk("rst_mode", set_mode, 0);
    chk("rst_inc", inc, 0);
    chk("rst_dec", dec, 0);
    chk("rst_blink", blink, 0);
    rstn = 1'b1;
    step(2);

    // UP in RUN is discarded
    btn_up = 1'b1; step(10); btn_up = 1'b0; step(8);
    chk("run_inc_cnt", inc_cnt, 0);
    chk("run_en", set_enable, 0);
    chk("run_mode", set_mode, 0);

    press_mode();
    chk("m1_mode", set_mode, 6'b000001);
    chk("m1_en", set_enable, 1);
    press_mode();
    chk("m2_mode", set_mode, 6'b000010);
    press_mode();
    chk("m3_mode", set_mode, 6'b000100);
    chk("m3_blink", blink, 0);

    // SET_HOUR: glitch then clean press
    snap_inc = inc_cnt;
    btn_up = 1'b1; step(2); btn_up = 1'b0; step(10);
    chk("glitch_inc", inc_cnt - snap_inc, 0);
    snap_inc = inc_cnt; snap_dec = dec_cnt;
    btn_up = 1'b1;
    step(6); chk("inc_early", inc, 0);
    step(1); chk("inc_lat", inc, 1); chk("inc_lat_dec", dec, 0);
    step(1); chk("inc_width", inc, 0);
    step(2); btn_up = 1'b0; step(8);
    chk("clean_inc_cnt", inc_cnt - snap_inc, 1);
    chk("clean_dec_cnt", dec_cnt - snap_dec, 0);
    chk("hour_keep", set_mode, 6'b000100);

    repeat (4) press_mode();
    chk("wrap_mode", set_mode, 0);
    chk("wrap_en", set_enable, 0);

    // SET_MIN simultaneous events
    repeat (2) press_mode();
    chk("min_mode", set_mode, 6'b000010);
    snap_inc = inc_cnt; snap_dec = dec_cnt;
    btn_up = 1'b1; btn_down = 1'b1; step(10);
    btn_up = 1'b0; btn_down = 1'b0; step(8);
    chk("updn_inc", inc_cnt - snap_inc, 0);
    chk("updn_dec", dec_cnt - snap_dec, 0);
    snap_dec = dec_cnt;
    btn_mode = 1'b1; btn_down = 1'b1; step(10);
    btn_mode = 1'b0; btn_down = 1'b0; step(8);
    chk("mode_dn_mode", set_mode, 6'b000100);
    chk("mode_dn_dec", dec_cnt - snap_dec, 0);
    repeat (4) press_mode();
    chk("back_run_en", set_enable, 0);

    // timeout in SET_DAY, with an UP edge landing on the expiry cycle
    repeat (3) press_mode();
    btn_mode = 1'b1;
    step(6); chk("mode_lat_pre", set_mode, 6'b000100);
    step(1); chk("mode_lat", set_mode, 6'b001000);
    btn_mode = 1'b0;
    step(93);
    btn_up = 1'b1;
    step(6); chk("tmo_99_en", set_enable, 1);
    step(1);
    chk("tmo_edge_inc", inc, 1);
    chk("tmo_edge_keep", set_mode, 6'b001000);
    btn_up = 1'b0;
    step(99); chk("tmo_reload_en", set_enable, 1);
    step(1);
    chk("tmo_expire_en", set_enable, 0);
    chk("tmo_expire_mode", set_mode, 0);

    // held UP in SET_SEC: single pulse, or auto-repeat when enabled
    press_mode();
    chk("sec_mode", set_mode, 6'b000001);
    snap_inc = inc_cnt;
    btn_up = 1'b1;
    step(26); chk("rpt_e26", inc, 0);
    step(1); chk("rpt_e27", inc, AR);
    step(23); btn_up = 1'b0; step(10);
    chk("rpt_count", inc_cnt - snap_inc, (AR != 0) ? 7 : 1);

    // asynchronous reset while UP is held
    btn_up = 1'b1;
    step(7); chk("rst_pre_inc", inc, 1);
    rstn = 1'b0;
    #1;
    chk("arst_inc", inc, 0);
    chk("arst_en", set_enable, 0);
    chk("arst_mode", set_mode, 0);
    chk("arst_dec", dec, 0);
    chk("arst_blink", blink, 0);
    step(3);
    rstn = 1'b1;
    snap_inc = inc_cnt;
    step(30);
    chk("post_rst_inc", inc_cnt - snap_inc, 0);
    chk("post_rst_en", set_enable, 0);
    btn_up = 1'b0;
    step(10);

    chk("never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
